// File: rtl/scroll_sequencer_if.sv
// Bundles the button/collision/frame inputs and the scroll outputs of scroll_sequencer.
// master drives the inputs; slave is the sequencer itself.
interface scroll_sequencer_if;
  logic        frame_end;
  logic        start_pulse;
  logic        pause_pulse;
  logic        collision;
  logic        scroll_en;
  logic [2:0]  scroll_step;
  logic [3:0]  level;
  logic [15:0] distance;
  logic [1:0]  state;
  logic        game_over;

  modport master (
    output frame_end, start_pulse, pause_pulse, collision,
    input  scroll_en, scroll_step, level, distance, state, game_over
  );

  modport slave (
    input  frame_end, start_pulse, pause_pulse, collision,
    output scroll_en, scroll_step, level, distance, state, game_over
  );
endinterface

// File: rtl/scroll_sequencer.sv
// Round state machine for the vertical scroller: sets the per-frame scroll step,
// ramps it with level, decelerates to a stop after a collision and flags game over.
module scroll_sequencer #(
  parameter int unsigned FRAMES_PER_LEVEL = 600,
  parameter int unsigned MAX_LEVEL        = 7,
  parameter int unsigned BASE_STEP        = 1,
  parameter int unsigned MAX_STEP         = 6,
  parameter int unsigned DECEL_FRAMES     = 8
) (
  input logic               clk,
  input logic               reset,
  scroll_sequencer_if.slave bus
);

  localparam int unsigned FcW = (FRAMES_PER_LEVEL > 1) ? $clog2(FRAMES_PER_LEVEL) : 1;
  localparam int unsigned DcW = (DECEL_FRAMES > 1) ? $clog2(DECEL_FRAMES) : 1;
  localparam logic [FcW-1:0] FcLast = FcW'(FRAMES_PER_LEVEL - 1);
  localparam logic [DcW-1:0] DcLast = DcW'(DECEL_FRAMES - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StCrash = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     step_q, step_d;
  logic [3:0]     level_q, level_d;
  logic [15:0]    dist_q, dist_d;
  logic [FcW-1:0] fcnt_q, fcnt_d;
  logic [DcW-1:0] dcnt_q, dcnt_d;
  logic           go_q, go_d;
  logic           en_q, en_d;

  logic [16:0]    dist_sum;
  logic [15:0]    dist_sat;
  logic           level_wrap;
  logic [3:0]     level_next;
  logic [3:0]     step_sum;
  logic [2:0]     step_clamped;

  always_comb begin
    dist_sum     = {1'b0, dist_q} + 17'(step_q);
    dist_sat     = dist_sum[16] ? 16'hFFFF : dist_sum[15:0];
    level_wrap   = (fcnt_q == FcLast);
    level_next   = (level_wrap && (level_q != 4'(MAX_LEVEL))) ? level_q + 4'd1 : level_q;
    // 4-bit sum so BASE_STEP + MAX_LEVEL cannot wrap before the clamp
    step_sum     = 4'(BASE_STEP) + level_next;
    step_clamped = (step_sum > 4'(MAX_STEP)) ? 3'(MAX_STEP) : step_sum[2:0];

    state_d = state_q;
    step_d  = step_q;
    level_d = level_q;
    dist_d  = dist_q;
    fcnt_d  = fcnt_q;
    dcnt_d  = dcnt_q;
    go_d    = go_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start_pulse) begin
          state_d = StRun;
          level_d = '0;
          dist_d  = '0;
          fcnt_d  = '0;
          step_d  = 3'(BASE_STEP);
          go_d    = 1'b0;
        end
      end
      StRun: begin
        if (bus.collision) begin
          state_d = StCrash;
          dcnt_d  = '0;
        end else if (bus.pause_pulse) begin
          state_d = StPause;
        end else if (bus.frame_end) begin
          dist_d  = dist_sat;
          fcnt_d  = level_wrap ? '0 : fcnt_q + 1'b1;
          level_d = level_next;
          step_d  = step_clamped;
        end
      end
      StPause: begin
        if (bus.pause_pulse) begin
          state_d = StRun;
        end
      end
      StCrash: begin
        if (go_q && bus.start_pulse) begin
          state_d = StIdle;
          go_d    = 1'b0;
          step_d  = '0;
        end else begin
          if (bus.frame_end) begin
            dist_d = dist_sat;
            if (dcnt_q == DcLast) begin
              dcnt_d = '0;
              step_d = (step_q != 3'd0) ? step_q - 3'd1 : 3'd0;
            end else begin
              dcnt_d = dcnt_q + 1'b1;
            end
          end
          if (step_d == 3'd0) begin
            go_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered from next-state so it is valid the cycle after any transition
    en_d = ((state_d == StRun) || (state_d == StCrash)) && (step_d != 3'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      step_q  <= '0;
      level_q <= '0;
      dist_q  <= '0;
      fcnt_q  <= '0;
      dcnt_q  <= '0;
      go_q    <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      level_q <= level_d;
      dist_q  <= dist_d;
      fcnt_q  <= fcnt_d;
      dcnt_q  <= dcnt_d;
      go_q    <= go_d;
      en_q    <= en_d;
    end
  end

  assign bus.scroll_en   = en_q;
  assign bus.scroll_step = step_q;
  assign bus.level       = level_q;
  assign bus.distance    = dist_q;
  assign bus.state       = state_q;
  assign bus.game_over   = go_q;

endmodule

// File: tb/tb_scroll_sequencer.sv
// Bench for scroll_sequencer: directed round scenarios plus random stimulus,
// every cycle compared against a behavioural model of the round rules.
module tb_scroll_sequencer;

  localparam int FPL  = 4;
  localparam int MAXL = 7;
  localparam int BASE = 1;
  localparam int MAXS = 6;
  localparam int DECF = 2;

  logic clk;
  logic reset;
  scroll_sequencer_if bus ();

  scroll_sequencer #(
    .FRAMES_PER_LEVEL(FPL),
    .MAX_LEVEL       (MAXL),
    .BASE_STEP       (BASE),
    .MAX_STEP        (MAXS),
    .DECEL_FRAMES    (DECF)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  // Reference model: round rules in plain integers
  int m_state, m_step, m_level, m_dist, m_fcnt, m_dcnt, m_go, m_en;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int add_sat(input int a, input int b);
    return (a + b > 65535) ? 65535 : a + b;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_update();
    if (reset) begin
      m_state = 0; m_step = 0; m_level = 0; m_dist = 0;
      m_fcnt = 0; m_dcnt = 0; m_go = 0;
    end else begin
      case (m_state)
        0: if (bus.start_pulse) begin
          m_state = 1; m_level = 0; m_dist = 0; m_fcnt = 0; m_step = BASE; m_go = 0;
        end
        1: begin
          if (bus.collision) begin
            m_state = 3; m_dcnt = 0;
          end else if (bus.pause_pulse) begin
            m_state = 2;
          end else if (bus.frame_end) begin
            m_dist = add_sat(m_dist, m_step);
            m_fcnt++;
            if (m_fcnt == FPL) begin
              m_fcnt  = 0;
              m_level = min_i(m_level + 1, MAXL);
            end
            m_step = min_i(BASE + m_level, MAXS);
          end
        end
        2: if (bus.pause_pulse) m_state = 1;
        default: begin
          if (m_go == 1 && bus.start_pulse) begin
            m_state = 0; m_go = 0; m_step = 0;
          end else begin
            if (bus.frame_end) begin
              m_dist = add_sat(m_dist, m_step);
              m_dcnt++;
              if (m_dcnt == DECF) begin
                m_dcnt = 0;
                if (m_step > 0) m_step--;
              end
            end
            if (m_step == 0) m_go = 1;
          end
        end
      endcase
    end
    m_en = ((m_state == 1 || m_state == 3) && m_step != 0) ? 1 : 0;
  endtask

  function automatic logic [31:0] dut_vec();
    return {5'b0, bus.state, bus.scroll_en, bus.scroll_step, bus.level, bus.distance,
            bus.game_over};
  endfunction

  function automatic logic [31:0] model_vec();
    return {5'b0, 2'(m_state), 1'(m_en), 3'(m_step), 4'(m_level), 16'(m_dist), 1'(m_go)};
  endfunction

  // One clock: drive inputs, advance model at the edge, compare just after it
  task automatic tick(input logic r, input logic s, input logic p, input logic f,
                      input logic c);
    reset           = r;
    bus.start_pulse = s;
    bus.pause_pulse = p;
    bus.frame_end   = f;
    bus.collision   = c;
    @(posedge clk);
    model_update();
    #1;
    check_eq("model", dut_vec(), model_vec());
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle();
    end
  endtask

  task automatic restart();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic prev_f;
    n_cmp = 0;
    n_err = 0;
    m_state = 0; m_step = 0; m_level = 0; m_dist = 0;
    m_fcnt = 0; m_dcnt = 0; m_go = 0; m_en = 0;

    // Reset state
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_vec", dut_vec(), 32'h0);

    // Start, basic scrolling
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("start_state", 32'(bus.state), 32'd1);
    check_eq("start_step", 32'(bus.scroll_step), 32'd1);
    check_eq("start_en", 32'(bus.scroll_en), 32'd1);
    check_eq("start_dist", 32'(bus.distance), 32'd0);
    frames(3);
    check_eq("dist3", 32'(bus.distance), 32'd3);
    check_eq("level0", 32'(bus.level), 32'd0);
    frames(1);
    check_eq("level1", 32'(bus.level), 32'd1);
    check_eq("step2", 32'(bus.scroll_step), 32'd2);
    frames(28);
    check_eq("level7", 32'(bus.level), 32'd7);
    check_eq("step_clamp", 32'(bus.scroll_step), 32'd6);
    check_eq("dist32", 32'(bus.distance), 32'd132);
    frames(4);
    check_eq("level_sat", 32'(bus.level), 32'd7);

    // Pause freezes counters; frame counter resumes afterwards
    restart();
    frames(3);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("pause_state", 32'(bus.state), 32'd2);
    check_eq("pause_en", 32'(bus.scroll_en), 32'd0);
    frames(10);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("pause_dist", 32'(bus.distance), 32'd3);
    check_eq("pause_hold", 32'(bus.state), 32'd2);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("resume_state", 32'(bus.state), 32'd1);
    frames(1);
    check_eq("resume_dist", 32'(bus.distance), 32'd4);
    check_eq("resume_level", 32'(bus.level), 32'd1);

    // Crash from step 3, collision beats coincident frame_end
    restart();
    frames(8);
    check_eq("pre_crash_step", 32'(bus.scroll_step), 32'd3);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("crash_state", 32'(bus.state), 32'd3);
    check_eq("crash_dist", 32'(bus.distance), 32'd12);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("crash_start_ign", 32'(bus.state), 32'd3);
    frames(5);
    check_eq("decel_step1", 32'(bus.scroll_step), 32'd1);
    check_eq("decel_go0", 32'(bus.game_over), 32'd0);
    frames(1);
    check_eq("decel_step0", 32'(bus.scroll_step), 32'd0);
    check_eq("game_over", 32'(bus.game_over), 32'd1);
    check_eq("go_en", 32'(bus.scroll_en), 32'd0);
    check_eq("crash_dist12", 32'(bus.distance), 32'd24);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("go_idle", 32'(bus.state), 32'd0);
    check_eq("go_clear", 32'(bus.game_over), 32'd0);
    check_eq("go_level_hold", 32'(bus.level), 32'd2);
    check_eq("go_dist_hold", 32'(bus.distance), 32'd24);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("restart_state", 32'(bus.state), 32'd1);
    check_eq("restart_dist", 32'(bus.distance), 32'd0);

    // Distance saturation, then reset in mid-crash
    restart();
    frames(10932);
    check_eq("dist_near", 32'(bus.distance), 32'hFFFC);
    frames(1);
    check_eq("dist_sat", 32'(bus.distance), 32'hFFFF);
    frames(1);
    check_eq("dist_sat_hold", 32'(bus.distance), 32'hFFFF);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    frames(1);
    check_eq("sat_crash", 32'(bus.state), 32'd3);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("rst_crash", dut_vec(), 32'h0);

    // Reset while paused
    restart();
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("rst_pause", dut_vec(), 32'h0);

    // Random stimulus against the model
    prev_f = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      logic r, s, p, f, c;
      r = ($urandom_range(0, 399) == 0);
      s = ($urandom_range(0, 14) == 0);
      p = ($urandom_range(0, 29) == 0);
      f = !prev_f && ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 39) == 0);
      prev_f = f;
      tick(r, s, p, f, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
